// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port LPDDR2 controller arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Port indices: fetch path is port 0, load/store path is port 1.
  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  // Read data returned when the controller never answers.
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_grant
);

  // Combinational pick of the winning port index.
  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_IFETCH;
    if (&i_req)
      o_grant = ~i_last_grant;
    else if (i_req[PORT_DATA])
      o_grant = PORT_DATA;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the LPDDR2 controller port between instruction fetch (port 0) and
// data load/store (port 1). One transaction in flight; all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_req,
  output logic              write_req,
  input  logic              waiting,
  output logic              busy,
  output logic              err
);

  // Counter only needs to reach TIMEOUT-1; TIMEOUT = 0 lets it wrap unused.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       r_state;
  logic             r_last_grant;
  logic             r_gnt;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  logic              w_gnt_vld;
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_rval;

  rr_arbiter2 u_rr (
    .i_req        ({p1_req, p0_req}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_gnt_vld),
    .o_grant      (w_gnt)
  );

  assign w_we    = (w_gnt == PORT_DATA) ? p1_we    : p0_we;
  assign w_addr  = (w_gnt == PORT_DATA) ? p1_addr  : p0_addr;
  assign w_wdata = (w_gnt == PORT_DATA) ? p1_wdata : p0_wdata;

  // A falling waiting always wins over a timeout landing in the same cycle.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_finish  = waiting ? w_timeout : 1'b1;
  assign w_rval    = waiting ? DATA_W'(TIMEOUT_FILL) : read_data;

  // Transaction sequencer: grant, strobe, wait for the controller, ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_DATA;
      r_gnt        <= PORT_IFETCH;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      address      <= '0;
      write_data   <= '0;
      read_req     <= 1'b0;
      write_req    <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      read_req  <= 1'b0;
      write_req <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      case (r_state)
        IDLE: begin
          // A still-busy controller (e.g. reset mid-op) must drain first.
          if (w_gnt_vld && !waiting) begin
            r_gnt        <= w_gnt;
            r_last_grant <= w_gnt;
            r_we         <= w_we;
            address      <= w_addr;
            write_data   <= w_wdata;
            read_req     <= ~w_we;
            write_req    <= w_we;
            busy         <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_finish) begin
            if (waiting) err <= 1'b1;
            if (r_gnt == PORT_DATA) begin
              p1_ack <= 1'b1;
              if (!r_we) p1_rdata <= w_rval;
            end else begin
              p0_ack <= 1'b1;
              if (!r_we) p0_rdata <= w_rval;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data, read_data;
  logic          read_req, write_req, waiting, busy, err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .address(address), .write_data(write_data), .read_data(read_data),
    .read_req(read_req), .write_req(write_req), .waiting(waiting),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- controller model ----------------
  bit          ctl_stuck = 0;
  int          ctl_fix_hold = 0;
  bit          ctl_fix_data_en = 0;
  logic [31:0] ctl_fix_data = '0;
  int          c_hold = 0;

  initial begin
    bit s;
    waiting   = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      s = read_req | write_req;
      tick();
      read_data = $urandom;
      if (s) begin
        waiting = 1'b1;
        if (ctl_fix_hold != 0) c_hold = ctl_fix_hold;
        else if ($urandom_range(0, 7) == 0) c_hold = $urandom_range(7, 10);
        else c_hold = $urandom_range(1, 4);
      end else if (waiting && !ctl_stuck) begin
        c_hold--;
        if (c_hold <= 0) begin
          waiting = 1'b0;
          read_data = ctl_fix_data_en ? ctl_fix_data : $urandom;
        end
      end
    end
  end

  // ---------------- reference model + compare ----------------
  // A granted transaction occupies a timeline: strobe one cycle after the
  // grant, ack one cycle after waiting is seen low (or after TMO cycles of
  // waiting high), busy from strobe through ack.
  bit          m_open, m_last, m_port, m_we, m_err;
  int          t_strobe, t_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd [2];
  int          n_strobe = 0, n_wstrobe = 0, t_last_strobe = 0;

  initial begin
    int k;
    m_open = 0; m_last = 1; m_err = 0; m_addr = '0; m_wd = '0;
    m_rd[0] = '0; m_rd[1] = '0; t_strobe = 0; t_ack = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_read_req", read_req, 0);
        chk("rst_write_req", write_req, 0);
        chk("rst_p0_ack", p0_ack, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_address", address, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        m_open = 0; m_last = 1; m_err = 0; m_addr = '0; m_wd = '0;
        m_rd[0] = '0; m_rd[1] = '0; t_ack = -1;
      end else begin
        chk("read_req", read_req, m_open && cyc == t_strobe && !m_we);
        chk("write_req", write_req, m_open && cyc == t_strobe && m_we);
        chk("busy", busy, m_open && cyc >= t_strobe);
        chk("p0_ack", p0_ack, m_open && cyc == t_ack && m_port == 1'b0);
        chk("p1_ack", p1_ack, m_open && cyc == t_ack && m_port == 1'b1);
        chk("err", err, m_err);
        chk("address", address, m_addr);
        chk("write_data", write_data, m_wd);
        chk("p0_rdata", p0_rdata, m_rd[0]);
        chk("p1_rdata", p1_rdata, m_rd[1]);
        if (read_req || write_req) begin
          n_strobe++;
          t_last_strobe = cyc;
          if (write_req) n_wstrobe++;
        end
        if (m_open) begin
          if (t_ack < 0 && cyc > t_strobe) begin
            k = cyc - t_strobe - 1;
            if (!waiting) begin
              t_ack = cyc + 1;
              if (!m_we) m_rd[m_port] = read_data;
            end else if (TMO != 0 && k == TMO - 1) begin
              t_ack = cyc + 1;
              m_err = 1;
              if (!m_we) m_rd[m_port] = 32'hDEADBEEF;
            end
          end else if (cyc == t_ack) begin
            m_open = 0;
          end
        end else if ((p0_req || p1_req) && !waiting) begin
          m_port   = (p0_req && p1_req) ? !m_last : p1_req;
          m_last   = m_port;
          m_we     = m_port ? p1_we : p0_we;
          m_addr   = m_port ? p1_addr : p0_addr;
          m_wd     = m_port ? p1_wdata : p0_wdata;
          m_open   = 1;
          t_strobe = cyc + 1;
          t_ack    = -1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic wait_ack(input bit port, input int max, output int t);
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk(port ? "ack_p1_seen" : "ack_p0_seen", t >= 0, 1);
  endtask

  task automatic new0();
    p0_we = 1'($urandom_range(0, 1)); p0_addr = AW'($urandom); p0_wdata = $urandom;
  endtask

  task automatic new1();
    p1_we = 1'($urandom_range(0, 1)); p1_addr = AW'($urandom); p1_wdata = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, t0, s0;
    bit a0, a1;
    logic [1:0] order [4];
    int n_ord;
    rst = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    do_reset();

    // Minimum-latency read: waiting high one cycle -> ack at cycle 4.
    ctl_fix_hold = 1; ctl_fix_data_en = 1; ctl_fix_data = 32'h11112222;
    p0_req = 1; p0_we = 0; p0_addr = 27'h0AA; t0 = cyc;
    wait_ack(0, 30, t);
    chk("lat_min", t - t0, 4);
    chk("rdata_min", p0_rdata, 32'h11112222);
    tick(); p0_req = 0; tick();

    // Single read, waiting high three cycles -> ack at cycle 6.
    ctl_fix_hold = 3; ctl_fix_data = 32'hCAFE0001;
    p0_req = 1; p0_addr = 27'h100; t0 = cyc;
    wait_ack(0, 30, t);
    chk("lat_read", t - t0, 6);
    chk("rdata_read", p0_rdata, 32'hCAFE0001);
    chk("addr_read", address, 27'h100);
    tick(); p0_req = 0; tick();

    // Single write on port 1.
    ctl_fix_hold = 2;
    s0 = n_wstrobe;
    p1_req = 1; p1_we = 1; p1_addr = 27'h4; p1_wdata = 32'h12345678;
    wait_ack(1, 30, t);
    chk("wdata_write", write_data, 32'h12345678);
    chk("addr_write", address, 27'h4);
    chk("p1_rdata_kept", p1_rdata, 0);
    chk("p0_rdata_kept", p0_rdata, 32'hCAFE0001);
    chk("one_wstrobe", n_wstrobe - s0, 1);
    tick(); p1_req = 0; tick();

    // Contention: both held, grants alternate starting with port 0.
    ctl_fix_hold = 0; ctl_fix_data_en = 0;
    for (int i = 0; i < 4; i++) order[i] = 2'd3;
    n_ord = 0;
    p0_req = 1; p0_we = 0; p1_req = 1; p1_we = 0;
    for (int i = 0; i < 200 && n_ord < 4; i++) begin
      @(negedge clk);
      if (p0_ack && n_ord < 4) begin order[n_ord] = 2'd0; n_ord++; end
      if (p1_ack && n_ord < 4) begin order[n_ord] = 2'd1; n_ord++; end
    end
    tick(); p0_req = 0; p1_req = 0;
    chk("rr_count", n_ord, 4);
    chk("rr_0", order[0], 0);
    chk("rr_1", order[1], 1);
    chk("rr_2", order[2], 0);
    chk("rr_3", order[3], 1);
    repeat (12) tick();

    // Timeout: waiting stuck high on a port 0 read.
    ctl_stuck = 1; ctl_fix_hold = 2;
    p0_req = 1; p0_we = 0; p0_addr = 27'h55;
    wait_ack(0, 40, t);
    chk("tmo_ack_delay", t - t_last_strobe, 9);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", p0_rdata, 32'hDEADBEEF);
    tick(); p0_req = 0;
    p1_req = 1; p1_we = 0; p1_addr = 27'h7;
    s0 = n_strobe;
    repeat (6) tick();
    chk("tmo_no_strobe", n_strobe - s0, 0);
    chk("tmo_idle", busy, 0);
    ctl_stuck = 0;
    wait_ack(1, 40, t);
    chk("tmo_err_sticky", err, 1);
    tick(); p1_req = 0; tick();

    // Reset mid-BUSY with waiting high and p0_req held.
    do_reset();
    chk("err_cleared", err, 0);
    ctl_stuck = 1; ctl_fix_hold = 2;
    p0_req = 1; p0_we = 0; p0_addr = 27'h9;
    repeat (4) tick();
    chk("busy_before_rst", busy, 1);
    rst = 0;
    repeat (2) tick();
    rst = 1;
    s0 = n_strobe;
    repeat (5) tick();
    chk("drain_no_strobe", n_strobe - s0, 0);
    ctl_stuck = 0;
    wait_ack(0, 40, t);
    chk("fresh_grant", n_strobe - s0, 1);
    tick(); p0_req = 0; tick();

    // Request dropped during BUSY still completes.
    ctl_fix_hold = 3;
    s0 = n_strobe;
    p1_req = 1; p1_we = 0; p1_addr = 27'h12;
    for (int i = 0; i < 20 && n_strobe == s0; i++) tick();
    tick(); p1_req = 0;
    wait_ack(1, 30, t);
    tick();
    chk("drop_busy_low", busy, 0);
    tick();

    // Random traffic.
    ctl_fix_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a0 = p0_ack; a1 = p1_ack;
      tick();
      if (p0_req && a0) begin
        p0_req = ($urandom_range(0, 2) == 0);
        if (p0_req) new0();
      end else if (!p0_req && $urandom_range(0, 3) == 0) begin
        p0_req = 1; new0();
      end
      if (p1_req && a1) begin
        p1_req = ($urandom_range(0, 2) == 0);
        if (p1_req) new1();
      end else if (!p1_req && $urandom_range(0, 3) == 0) begin
        p1_req = 1; new1();
      end
    end
    // Let any last transaction finish; drop requests right after their ack.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a0 = p0_ack; a1 = p1_ack;
      tick();
      if (a0) p0_req = 0;
      if (a1) p1_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
